mips_instr_encoder: RTL
=======================

Name: mips_instr_encoder

Overview:
- Counterpart to the per-stage instruction decoders. Takes symbolic instructions (op class plus register/immediate fields) over a valid/ready handshake.
- Encodes each one into a 32-bit MIPS machine word for the CPU's supported subset.
- Writes the words sequentially into instruction memory (IM) through a synchronous write port.
- Used as the bench/boot loader that fills IM before the pipeline is released from reset.

Parameters:
- IM_DEPTH, 1024, number of 32-bit words in IM
- ADDR_W, 10, IM word-address width; must satisfy 2^ADDR_W >= IM_DEPTH
- PC_BASE, 32'h0000_3000, byte address of IM word 0; used only for the im_pc output

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- restart  in  1  synchronous pulse; clears the write pointer and status, then returns to IDLE.
- in_valid  in  1  the in_* fields hold an instruction.
- in_ready  out  1  encoder can accept an instruction this cycle.
- in_op  in  4  op class: 0 NOP, 1 ADDU, 2 SUBU, 3 ORI, 4 LUI, 5 LW, 6 SW, 7 BEQ, 8 J, 9 JAL, 10 JR; 11-15 illegal.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_imm  in  26  [15:0] imm16 for I-type; [25:0] instr_index for J/JAL.
- in_last  in  1  this is the final instruction of the program.
- im_we  out  1  IM write enable, one-cycle pulse.
- im_addr  out  ADDR_W  IM word address.
- im_wdata  out  32  encoded machine word.
- im_pc  out  32  byte PC of the word being written: PC_BASE + 4*im_addr.
- count  out  ADDR_W+1  number of words written since reset or restart.
- done  out  1  sticky; program completed (in_last seen, or IM full).
- full  out  1  sticky; IM_DEPTH words have been written.
- err  out  1  sticky; an illegal op was received.

Behaviour:
- Reset (async): state IDLE. All outputs 0 except in_ready=1. Write pointer and count cleared.
- Encoding (opcode, field layout, funct):
  - ADDU: 000000, rs rt rd 00000, funct 100001.
  - SUBU: 000000, rs rt rd 00000, funct 100011.
  - JR: 000000, rs 00000 00000 00000, funct 001000.
  - ORI: 001101, rs rt imm16.
  - LUI: 001111, 00000 rt imm16. rs input is ignored.
  - LW: 100011, rs rt imm16.
  - SW: 101011, rs rt imm16.
  - BEQ: 000100, rs rt imm16.
  - J: 000010, instr_index.
  - JAL: 000011, instr_index.
  - NOP: 32'h0000_0000.
  - Fields not used by an op are forced to 0 regardless of input.
- States:
  - IDLE: in_ready=1.
    - On in_valid with a legal op: register the encoded word and the last flag; go to WRITE.
    - On in_valid with an illegal op: set err; go to HALT. Nothing is written.
  - WRITE: in_ready=0. Registered outputs im_we=1, im_addr=wptr, im_wdata=word, im_pc=PC_BASE+{wptr,2'b00}. At the end of the cycle wptr and count increment.
    - If last, or wptr==IM_DEPTH-1: set done (and full when the pointer hits the end); go to HALT.
    - Otherwise go to IDLE.
  - HALT: in_ready=0, im_we=0. in_valid is ignored. Leaves only on restart or reset.
- Handshake: a transfer occurs on a rising edge with in_valid&&in_ready. Peak throughput is one instruction per 2 cycles. in_ready depends only on state, never on in_valid.
- im_we is high for exactly one cycle per accepted legal instruction. im_addr and im_wdata hold their last values when im_we=0.
- restart:
  - Has priority over all state transitions in every state.
  - Next cycle: state IDLE, wptr=0, count=0, done=full=err=0, im_we=0.
  - A restart issued in WRITE aborts that write: im_we is not asserted for the aborted word.
- Boundary cases:
  - Exactly IM_DEPTH words written without in_last: count=IM_DEPTH, full=done=1.
  - in_last on the final IM slot also gives full=done=1.
  - wptr never wraps.
- Reset asserted mid-WRITE forces im_we low immediately; the write is lost.

Test Plan:
- Reset, then ADDU rs=1 rt=2 rd=3 -> im_we pulse 2 cycles after acceptance, im_addr=0, im_wdata=32'h0022_1821, im_pc=32'h0000_3000, count=1.
- Stream ORI rs=0 rt=8 imm=16'h1234; LUI rt=9 imm=16'hABCD with rs=5; LW rs=8 rt=10 imm=4; SW rs=8 rt=10 imm=8 -> words 32'h3408_1234, 32'h3C09_ABCD, 32'h8D0A_0004, 32'hAD0A_0008 at addresses 0..3; in_ready low during every WRITE cycle.
- BEQ rs=1 rt=2 imm=16'hFFFF, then J idx=26'h0000C00, JAL idx=26'h0000C01, JR rs=31 with in_last=1 -> words 32'h1022_FFFF, 32'h0800_0C00, 32'h0C00_0C01, 32'h03E0_0008; done=1, in_ready stays 0, further in_valid ignored.
- in_op=12 on the second instruction -> err=1, no im_we, count=1. restart -> err=0, count=0, next word written at im_addr=0.
- IM_DEPTH=4, feed 6 NOPs with no in_last -> exactly 4 writes at addresses 0..3, full=done=1, count=4.
- Assert restart during a WRITE cycle and, separately, reset mid-stream -> no im_we for the aborted word, count=0, in_ready=1 on the next cycle.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - symbolic instruction to MIPS word encoder that loads IM
//
// Accepts one symbolic instruction per valid/ready transfer, encodes it into a
// 32-bit MIPS machine word, and writes it to the next sequential IM slot.
// Ports:
//   clk, reset (async, active-high), restart (sync pulse)
//   in_valid/in_ready handshake; in_op, in_rs, in_rt, in_rd, in_imm, in_last fields
//   im_we/im_addr/im_wdata/im_pc synchronous IM write port (registered)
//   count, done, full, err status (registered, sticky until restart/reset)
module mips_instr_encoder #(
    parameter int unsigned IM_DEPTH = 1024,
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] PC_BASE  = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [31:0]       im_pc,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_HALT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       pc_q, pc_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic [31:0]       enc_word;
    logic              enc_legal;

    // Unused fields of each format are hard-wired to zero.
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = 32'h0000_0000;
        case (in_op)
            4'd0:    enc_word = 32'h0000_0000;
            4'd1:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
            4'd2:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100011};
            4'd3:    enc_word = {6'b001101, in_rs, in_rt, in_imm[15:0]};
            4'd4:    enc_word = {6'b001111, 5'b00000, in_rt, in_imm[15:0]};
            4'd5:    enc_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
            4'd6:    enc_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
            4'd7:    enc_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
            4'd8:    enc_word = {6'b000010, in_imm};
            4'd9:    enc_word = {6'b000011, in_imm};
            4'd10:   enc_word = {6'b000000, in_rs, 15'b0, 6'b001000};
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        done_d  = done_q;
        full_d  = full_q;
        err_d   = err_q;
        if (restart) begin
            // Dropping straight to IDLE here is what aborts a pending WRITE.
            state_d = ST_IDLE;
            wptr_d  = '0;
            count_d = '0;
            done_d  = 1'b0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (enc_legal) begin
                            word_d  = enc_word;
                            last_d  = in_last;
                            state_d = ST_WRITE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end
                    end
                end
                ST_WRITE: begin
                    we_d    = 1'b1;
                    addr_d  = wptr_q;
                    wdata_d = word_q;
                    pc_d    = PC_BASE + (32'(wptr_q) << 2);
                    count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
                    if (wptr_q == ADDR_W'(IM_DEPTH - 1)) begin
                        // Pointer is parked on the last slot rather than wrapped.
                        full_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        wptr_d = wptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (last_q) begin
                            done_d  = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            last_q  <= 1'b0;
            wptr_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign im_pc    = pc_q;
    assign count    = count_q;
    assign done     = done_q;
    assign full     = full_q;
    assign err      = err_q;

endmodule
